// File: rtl/array_cmp_pkg.sv
// Shared types and width helpers for the array compare engine.
package array_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StDone
  } state_e;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/array_compare_engine_if.sv
// Write port, compare control and result bus of the array compare engine.
interface array_compare_engine_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
);
  localparam int unsigned IdxW = array_cmp_pkg::idx_w(DEPTH);
  localparam int unsigned CntW = array_cmp_pkg::cnt_w(DEPTH);

  logic            wr_en;
  logic            wr_sel;
  logic [IdxW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            match;
  logic [IdxW-1:0] mismatch_idx;
  logic [CntW-1:0] mismatch_cnt;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, match, mismatch_idx, mismatch_cnt
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, match, mismatch_idx, mismatch_cnt
  );

endinterface

// File: rtl/array_bank.sv
// Storage bank: synchronous clear, range-checked write port, combinational read port.
module array_bank
  import array_cmp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned IdxW = idx_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [IdxW-1:0]  wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IdxW-1:0]  rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (32'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Out-of-range addresses only exist for non-power-of-two depths.
  assign rd_data_o = (32'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/array_compare_engine.sv
// Two-bank compare engine: walks both banks one index per cycle and latches match,
// first mismatch index and mismatch count when the walk completes.
module array_compare_engine
  import array_cmp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  array_compare_engine_if.slave  bus
);

  localparam int unsigned IdxW = idx_w(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  first_q, first_d;
  logic             found_q, found_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             match_q, match_d;
  logic [IdxW-1:0]  midx_q, midx_d;
  logic [CntW-1:0]  mcnt_q, mcnt_d;

  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_a, wr_b, neq;

  // Writes are only accepted while idle so a running compare sees stable banks.
  assign wr_a = bus.wr_en && (state_q == StIdle) && !bus.wr_sel;
  assign wr_b = bus.wr_en && (state_q == StIdle) && bus.wr_sel;

  array_bank #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_bank_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_a),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_a)
  );

  array_bank #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_bank_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_b),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_b)
  );

  assign neq = (rd_a != rd_b);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    found_d = found_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    midx_d  = midx_q;
    mcnt_d  = mcnt_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCompare;
          idx_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StCompare: begin
        if (neq) begin
          cnt_d = cnt_q + CntW'(1);
          if (!found_q) begin
            found_d = 1'b1;
            first_d = idx_q;
          end
        end
        if (idx_q == LastIdx) begin
          // Results are latched on entry to DONE so they are valid with the done pulse.
          state_d = StDone;
          match_d = (cnt_d == '0);
          midx_d  = first_d;
          mcnt_d  = cnt_d;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      match_q <= 1'b1;
      midx_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      midx_q  <= midx_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign bus.busy         = (state_q == StCompare);
  assign bus.done         = (state_q == StDone);
  assign bus.match        = match_q;
  assign bus.mismatch_idx = midx_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_array_compare_engine.sv
// Self-checking bench for array_compare_engine: vector table, corner sequences, random sweep.
module tb_array_compare_engine;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WIDTH  = 2;
  localparam int          Budget = 20;

  logic clk;
  logic rst;

  int total;
  int bad;

  int ref_a [DEPTH];
  int ref_b [DEPTH];

  array_compare_engine_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  array_compare_engine #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    a [DEPTH];
    int    b [DEPTH];
    int    em;
    int    ei;
    int    ec;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_a[i] = 0;
      ref_b[i] = 0;
    end
  endtask

  task automatic do_write(input int sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel[0];
    bus.wr_addr = addr[1:0];
    bus.wr_data = data[1:0];
    tick();
    bus.wr_en = 1'b0;
    if (addr < int'(DEPTH)) begin
      if (sel == 0) ref_a[addr] = data;
      else ref_b[addr] = data;
    end
  endtask

  // Reference: the result is a pure function of the two bank contents.
  function automatic void ref_cmp(output int m, output int fi, output int c);
    c  = 0;
    fi = -1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ref_a[i] != ref_b[i]) begin
        c++;
        if (fi < 0) fi = i;
      end
    end
    m = (c == 0) ? 1 : 0;
    if (fi < 0) fi = 0;
  endfunction

  // Pulses start (any wr_* already driven by the caller rides along), waits for done,
  // optionally pokes a write and a restart while busy (at wait step poke_busy) or in DONE.
  task automatic run(input string name, input int em, input int ei, input int ec,
                     input int poke_busy, input bit poke_done);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    n = 0;
    while (!bus.done && n < Budget) begin
      if (n == poke_busy) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 2'd3;
        bus.start   = 1'b1;
      end
      tick();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      n++;
    end
    check({name, ".latency"}, n, int'(DEPTH));
    check({name, ".busy_in_done"}, int'(bus.busy), 0);
    check({name, ".match"}, int'(bus.match), em);
    check({name, ".idx"}, int'(bus.mismatch_idx), ei);
    check({name, ".cnt"}, int'(bus.mismatch_cnt), ec);
    if (poke_done) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b1;
      bus.wr_addr = 2'd0;
      bus.wr_data = 2'd3;
      bus.start   = 1'b1;
    end
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check({name, ".done_width"}, int'(bus.done), 0);
    check({name, ".no_restart"}, int'(bus.busy), 0);
  endtask

  task automatic load(input int a [DEPTH], input int b [DEPTH]);
    for (int i = 0; i < int'(DEPTH); i++) do_write(0, i, a[i]);
    for (int i = 0; i < int'(DEPTH); i++) do_write(1, i, b[i]);
  endtask

  initial begin
    int m, fi, c, dones;
    int va [DEPTH];
    int vb [DEPTH];
    total = 0;
    bad   = 0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    rst         = 1'b0;

    vecs[0] = '{"same",    '{1, 2, 3, 0}, '{1, 2, 3, 0}, 1, 0, 0};
    vecs[1] = '{"two",     '{1, 2, 3, 0}, '{1, 3, 3, 1}, 0, 1, 2};
    vecs[2] = '{"all",     '{0, 0, 0, 0}, '{3, 3, 3, 3}, 0, 0, 4};
    vecs[3] = '{"last",    '{2, 1, 0, 3}, '{2, 1, 0, 1}, 0, 3, 1};
    vecs[4] = '{"bitexact", '{3, 3, 1, 2}, '{3, 2, 1, 0}, 0, 1, 2};

    do_reset();
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check("rst.match", int'(bus.match), 1);
    check("rst.idx", int'(bus.mismatch_idx), 0);
    check("rst.cnt", int'(bus.mismatch_cnt), 0);

    run("empty", 1, 0, 0, -1, 1'b0);

    foreach (vecs[k]) begin
      load(vecs[k].a, vecs[k].b);
      run(vecs[k].name, vecs[k].em, vecs[k].ei, vecs[k].ec, -1, 1'b0);
    end

    // Write and restart while busy, then again while in DONE: all ignored.
    va = '{1, 2, 3, 0};
    vb = '{1, 3, 3, 1};
    load(va, vb);
    run("poke", 0, 1, 2, 1, 1'b1);
    run("poke_after", 0, 1, 2, -1, 1'b0);

    // Reset during the second COMPARE cycle aborts without a done pulse.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_a[i] = 0;
      ref_b[i] = 0;
    end
    check("abort.busy", int'(bus.busy), 0);
    check("abort.match", int'(bus.match), 1);
    check("abort.idx", int'(bus.mismatch_idx), 0);
    check("abort.cnt", int'(bus.mismatch_cnt), 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort.no_done", dones, 0);
    run("abort_clear", 1, 0, 0, -1, 1'b0);

    // Same-cycle write and start: the write is part of the compare.
    do_write(0, 3, 0);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 2'd2;
    ref_b[3]    = 2;
    run("samecyc", 0, 3, 1, -1, 1'b0);

    for (int r = 0; r < 200; r++) begin
      int nw;
      nw = int'($urandom_range(0, 6));
      for (int w = 0; w < nw; w++) begin
        do_write(int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 1) == 1) begin
        int s, a, d;
        s = int'($urandom_range(0, 1));
        a = int'($urandom_range(0, DEPTH - 1));
        d = int'($urandom_range(0, 3));
        bus.wr_en   = 1'b1;
        bus.wr_sel  = s[0];
        bus.wr_addr = a[1:0];
        bus.wr_data = d[1:0];
        if (s == 0) ref_a[a] = d;
        else ref_b[a] = d;
      end
      ref_cmp(m, fi, c);
      run($sformatf("rand%0d", r), m, fi, c, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
